// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: serves one load/store per request with a fixed wait.
// Latency: ready rises WAIT_CYCLES cycles after a request is first seen in IDLE; Data_Out is registered.
// Backpressure: ready stays low while a request is outstanding; the pipeline holds its request until ready=1.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] Address,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        ready,
  output logic        addr_err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdat_q;
  logic               store_q;
  logic               inr_q;
  logic [31:0]        dout_q, dout_d;
  logic               err_q, err_d;

  logic [31:0]        mem_q [DEPTH];

  logic               req;
  logic [31:0]        offset;
  logic               in_range;
  logic [IDX_W-1:0]   idx_w;

  // Commit controls: sourced from live inputs when IDLE jumps straight to DONE,
  // otherwise from the request captured in IDLE.
  logic               commit;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_dat;
  logic               c_store;
  logic               c_inr;

  assign req      = MEM_R_EN | MEM_W_EN;
  // Subtracting first turns the two-sided range test into one unsigned compare.
  assign offset   = Address - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign idx_w    = offset[IDX_W+1:2];

  // Next-state, ready and commit selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    commit  = 1'b0;
    c_idx   = idx_q;
    c_dat   = wdat_q;
    c_store = store_q;
    c_inr   = inr_q;
    case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          if (WAIT_CYCLES == 1) begin
            state_d = S_DONE;
            commit  = 1'b1;
            c_idx   = idx_w;
            c_dat   = Data_In;
            c_store = MEM_W_EN;
            c_inr   = in_range;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        ready = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Load data and error flag produced on the edge entering DONE.
  always_comb begin
    dout_d = dout_q;
    err_d  = 1'b0;
    if (commit) begin
      err_d = ~c_inr;
      if (!c_store) begin
        dout_d = c_inr ? mem_q[c_idx] : 32'd0;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Capture the request in IDLE; later input changes are ignored until the next IDLE.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && req) begin
      idx_q   <= idx_w;
      wdat_q  <= Data_In;
      store_q <= MEM_W_EN;
      inr_q   <= in_range;
    end
  end

  // Array write: only in-range stores, only on entry to DONE, never on a reset edge.
  always_ff @(posedge CLK) begin
    if (RST && commit && c_store && c_inr) begin
      mem_q[c_idx] <= c_dat;
    end
  end

  assign Data_Out = dout_q;
  assign addr_err = err_q;

endmodule
